// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 constants, unpacked-operand type and unpack helper
package fp32_pkg;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W = 8;
    localparam int FRAC_W = 23;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   sig;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } unpacked_t;

    // denormals take effective exponent 1 with a clear hidden bit
    function automatic unpacked_t unpack(input logic [31:0] x);
        unpacked_t u;
        logic [EXP_W-1:0] e;
        logic [FRAC_W-1:0] f;
        e = x[30:23];
        f = x[22:0];
        u.sign = x[31];
        u.exp = (e == '0) ? EXP_W'(1) : e;
        u.sig = {e != '0, f};
        u.is_zero = (e == '0) && (f == '0);
        u.is_inf = (&e) && (f == '0);
        u.is_nan = (&e) && (f != '0);
        return u;
    endfunction
endpackage

// File: rtl/lzc24.sv
// lzc24: combinational leading-zero count of a 24-bit vector (24 when all zero)
module lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++)
            if (value[i]) count = 5'(23 - i);
    end
endmodule

// File: rtl/adder.sv
// adder: 4-stage pipelined IEEE-754 binary32 adder, round-to-nearest-even
module adder (
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic [31:0] output_z,
    input  logic        clk,
    input  logic        rst_n
);
    import fp32_pkg::*;

    unpacked_t a1, b1, lg, sm;
    logic [31:0] ra1, rb1, spv_c, spv2, spv3;
    logic        sp_c, sp2, sp3, swap, sign2, sub2, sign3, up;
    logic [7:0]  exp2, exp3, diff, lim, shamt;
    logic [26:0] big2, small2, sm_al, mant;
    logic [49:0] ext;
    logic [27:0] sum_c, sum3;
    logic [4:0]  lz;
    logic [9:0]  e, e_fin;
    logic [24:0] rnd;
    logic [31:0] norm;

    // special cases resolved from the unpacked operands, carried alongside the datapath
    always_comb begin
        sp_c = 1'b1;
        spv_c = QNAN;
        if (a1.is_nan || b1.is_nan || (a1.is_inf && b1.is_inf && (a1.sign ^ b1.sign))) spv_c = QNAN;
        else if (a1.is_inf) spv_c = ra1;
        else if (b1.is_inf) spv_c = rb1;
        else if (a1.is_zero && b1.is_zero) spv_c = {a1.sign & b1.sign, 31'b0};
        else if (a1.is_zero) spv_c = rb1;
        else if (b1.is_zero) spv_c = ra1;
        else sp_c = 1'b0;
    end

    assign swap = {b1.exp, b1.sig} > {a1.exp, a1.sig};
    assign lg = swap ? b1 : a1;
    assign sm = swap ? a1 : b1;
    assign diff = lg.exp - sm.exp;
    assign ext = {sm.sig, 26'b0} >> diff;
    assign sm_al = (diff >= 8'd27) ? {26'b0, |sm.sig} : {ext[49:24], |ext[23:0]};

    assign sum_c = sub2 ? {1'b0, big2} - {1'b0, small2} : {1'b0, big2} + {1'b0, small2};

    lzc24 u_lzc (.value(sum3[26:3]), .count(lz));

    // left shift stops at exponent 1 so tiny results stay denormal
    assign lim = exp3 - 8'd1;
    assign shamt = ({3'b0, lz} < lim) ? {3'b0, lz} : lim;
    assign mant = sum3[27] ? {sum3[27:2], |sum3[1:0]} : sum3[26:0] << shamt;
    assign e = sum3[27] ? {2'b0, exp3} + 10'd1 : {2'b0, exp3 - shamt};
    assign up = mant[2] & (mant[1] | mant[0] | mant[3]);
    assign rnd = {1'b0, mant[26:3]} + {24'b0, up};
    assign e_fin = rnd[24] ? e + 10'd1 : (rnd[23] ? e : 10'd0);
    assign norm = (sum3 == '0) ? 32'h0 :
                  (e_fin >= 10'd255) ? {sign3, POS_INF[30:0]} :
                  {sign3, e_fin[7:0], rnd[24] ? 23'b0 : rnd[22:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra1 <= '0;
            rb1 <= '0;
            a1 <= '0;
            b1 <= '0;
            sp2 <= 1'b0;
            spv2 <= '0;
            sign2 <= 1'b0;
            exp2 <= '0;
            big2 <= '0;
            small2 <= '0;
            sub2 <= 1'b0;
            sp3 <= 1'b0;
            spv3 <= '0;
            sign3 <= 1'b0;
            exp3 <= '0;
            sum3 <= '0;
            output_z <= '0;
        end else begin
            ra1 <= input_a;
            rb1 <= input_b;
            a1 <= unpack(input_a);
            b1 <= unpack(input_b);
            sp2 <= sp_c;
            spv2 <= spv_c;
            sign2 <= lg.sign;
            exp2 <= lg.exp;
            big2 <= {lg.sig, 3'b0};
            small2 <= sm_al;
            sub2 <= a1.sign ^ b1.sign;
            sp3 <= sp2;
            spv3 <= spv2;
            sign3 <= sign2;
            exp3 <= exp2;
            sum3 <= sum_c;
            output_z <= sp3 ? spv3 : norm;
        end
    end
endmodule

// File: tb/tb_adder.sv
// tb_adder: directed-vector bench for the pipelined binary32 adder
module tb_adder;
    logic [31:0] a, b, z;
    logic        clk, rst_n;
    int          total, bad;

    // {input_a, input_b, expected output_z}
    logic [95:0] tbl [15] = '{
        {32'h40B00000, 32'hC0F00000, 32'hC0000000},
        {32'h4154CCCD, 32'h4111C28F, 32'h41B347AE},
        {32'h3F800000, 32'h33800000, 32'h3F800000},
        {32'h3F800001, 32'h33800000, 32'h3F800002},
        {32'h3F800000, 32'h34000000, 32'h3F800001},
        {32'h3F800000, 32'hBF800000, 32'h00000000},
        {32'h80000000, 32'h80000000, 32'h80000000},
        {32'h00000000, 32'h80000000, 32'h00000000},
        {32'h00000001, 32'h00000001, 32'h00000002},
        {32'h00400000, 32'h00400000, 32'h00800000},
        {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
        {32'h7F800000, 32'hFF800000, 32'h7FC00000},
        {32'h7FC00001, 32'h3F800000, 32'h7FC00000},
        {32'h7F800000, 32'h3F800000, 32'h7F800000},
        {32'h40400000, 32'hBF800000, 32'h40000000}
    };

    adder dut (
        .input_a(a),
        .input_b(b),
        .output_z(z),
        .clk(clk),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // back-to-back entries lo..hi; result of entry c is checked after its 4th edge
    task automatic run(input int lo, input int hi, input bit pre);
        for (int c = lo; c <= hi + 3; c++) begin
            a = (c <= hi) ? tbl[c][95:64] : 32'h0;
            b = (c <= hi) ? tbl[c][63:32] : 32'h0;
            @(posedge clk);
            #1;
            if (c >= lo + 3) check($sformatf("v%0d", c - 3), z, tbl[c - 3][31:0]);
            else if (pre) check($sformatf("pre%0d", c - lo), z, 32'h0);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst", z, 32'h0);
        rst_n = 1'b1;
        run(0, 14, 1'b1);
        a = 32'h40B00000;
        b = 32'hC0F00000;
        repeat (4) @(posedge clk);
        #1;
        check("prerst", z, 32'hC0000000);
        a = 32'h3F800000;
        b = 32'h3F800000;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async", z, 32'h0);
        @(posedge clk);
        #1;
        check("inrst", z, 32'h0);
        rst_n = 1'b1;
        run(14, 14, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
